cdc_handshake_tx: RTL and testbench

CDC_HANDSHAKE_TX -- requirements
Module: cdc_handshake_tx

---
 rtl/cdc_handshake_tx.sv | 128 ++++++++++++
 tb/tb_cdc_handshake_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a 4-phase req/ack handshake. It captures one payload
// word and raises req, then waits for the synchronized ack to rise and fall.
// An optional watchdog stops a transfer that never receives an ack.
module cdc_handshake_tx #(
  parameter int WIDTH      = 8,
  parameter int SYNC_STAGE = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             res,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             req,
  output logic [WIDTH-1:0] dout,
  input  logic             ack,
  output logic             done,
  output logic             timeout
);

  // A zero TIMEOUT leaves a 1-bit counter that never moves.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_ACK     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t                state_r;
  logic [SYNC_STAGE-1:0] ack_sync_r;
  logic                  ack_s;
  logic                  req_r;
  logic [WIDTH-1:0]      dout_r;
  logic                  done_r;
  logic                  timeout_r;
  logic                  aborted_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  ready_s;
  logic                  cnt_hit_s;

  // The final synchronizer stage is the only copy of ack that the FSM reads.
  assign ack_s = ack_sync_r[SYNC_STAGE-1];

  // ready comes from the state register alone, so it has no path from valid.
  assign ready_s = (state_r == IDLE);

  // cnt_hit_s means the counter reaches TIMEOUT at this edge.
  always_comb begin
    if (TIMEOUT != 0) begin
      cnt_hit_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    end else begin
      cnt_hit_s = 1'b0;
    end
  end

  // Synchronizer chain that carries ack in from the destination domain.
  always_ff @(posedge clk) begin
    if (res) begin
      ack_sync_r <= '0;
    end else begin
      ack_sync_r[0] <= ack;
      for (int i = 1; i < SYNC_STAGE; i++) begin
        ack_sync_r[i] <= ack_sync_r[i-1];
      end
    end
  end

  // Handshake FSM, including the payload register, status pulses and watchdog.
  always_ff @(posedge clk) begin
    if (res) begin
      state_r   <= IDLE;
      req_r     <= 1'b0;
      dout_r    <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      aborted_r <= 1'b0;
      cnt_r     <= '0;
    end else begin
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid && ready_s) begin
            dout_r    <= din;
            req_r     <= 1'b1;
            cnt_r     <= '0;
            aborted_r <= 1'b0;
            state_r   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (TIMEOUT != 0) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
          // A real ack wins over a watchdog expiry in the same cycle.
          if (ack_s) begin
            req_r   <= 1'b0;
            state_r <= WAIT_RELEASE;
          end else if (cnt_hit_s) begin
            req_r     <= 1'b0;
            timeout_r <= 1'b1;
            aborted_r <= 1'b1;
            state_r   <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          // An aborted transfer waits for ack to clear but reports no done.
          if (!ack_s) begin
            done_r  <= ~aborted_r;
            state_r <= IDLE;
          end
        end
        default: begin
          req_r   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign ready   = ready_s;
  assign req     = req_r;
  assign dout    = dout_r;
  assign done    = done_r;
  assign timeout = timeout_r;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx (WIDTH=8, SYNC_STAGE=2, TIMEOUT=4).
// A small peer model produces ack from req. peer_mode selects the ack source:
// 0 = manual/tied low, 1 = one cycle late, 2 = immediate, 3 = two cycles late.
module tb_cdc_handshake_tx;

  logic       clk = 1'b0;
  logic       res;
  logic       valid;
  logic [7:0] din;
  logic       ready;
  logic       req;
  logic [7:0] dout;
  logic       ack;
  logic       done;
  logic       timeout;

  logic [1:0] peer_mode;
  logic       ack_man;
  logic       req_q;
  logic       req_q2;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    int         exp_done;
    int         exp_to;
    int         exp_pulse_k;
    int         exp_ready_k;
    int         exp_req_cycles;
  } vec_t;

  vec_t vecs [5];

  cdc_handshake_tx #(
    .WIDTH     (8),
    .SYNC_STAGE(2),
    .TIMEOUT   (4)
  ) dut (
    .clk    (clk),
    .res    (res),
    .valid  (valid),
    .din    (din),
    .ready  (ready),
    .req    (req),
    .dout   (dout),
    .ack    (ack),
    .done   (done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Delayed copies of req used by the peer model.
  always @(posedge clk) begin
    req_q  <= req;
    req_q2 <= req_q;
  end

  assign ack = (peer_mode == 2'd1) ? req_q  :
               (peer_mode == 2'd2) ? req    :
               (peer_mode == 2'd3) ? req_q2 : ack_man;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n_done, n_to, pulse_k, ready_k, req_cyc, dout_bad, rises, unstable;
    logic       req_prev;
    logic [7:0] dout_prev;

    // Each row: din, peer mode, done count, timeout count, pulse edge, ready edge, req cycles.
    vecs[0] = '{8'hA5, 2'd2, 1, 0, 6, 6, 3};  // immediate ack: minimum latency 2*2+2
    vecs[1] = '{8'h3C, 2'd1, 1, 0, 8, 8, 4};  // ack_s rises as the counter reaches 4
    vecs[2] = '{8'h00, 2'd0, 0, 1, 4, 5, 4};  // ack tied low, so the transfer times out
    vecs[3] = '{8'hFF, 2'd3, 0, 1, 4, 9, 4};  // ack arrives too late and must still clear
    vecs[4] = '{8'h5A, 2'd2, 1, 0, 6, 6, 3};

    res = 1'b1; valid = 1'b0; din = 8'h00; peer_mode = 2'd0; ack_man = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", int'(ready), 1);
    check("reset_req", int'(req), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_done", int'(done), 0);
    check("reset_timeout", int'(timeout), 0);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", int'(ready), 1);

    // Single transfers taken from the table.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      peer_mode = vecs[v].mode;
      valid = 1'b1;
      din = vecs[v].din;
      @(posedge clk); #1;
      valid = 1'b0;
      din = ~vecs[v].din;
      check($sformatf("v%0d_req_after_accept", v), int'(req), 1);
      check($sformatf("v%0d_ready_after_accept", v), int'(ready), 0);
      n_done = 0; n_to = 0; pulse_k = -1; ready_k = -1; dout_bad = 0;
      req_cyc = int'(req);
      for (int k = 1; k <= 20; k++) begin
        @(posedge clk); #1;
        if (req) begin
          req_cyc++;
          if (dout != vecs[v].din) dout_bad++;
        end
        if (done) begin n_done++; if (pulse_k < 0) pulse_k = k; end
        if (timeout) begin n_to++; if (pulse_k < 0) pulse_k = k; end
        if (ready && ready_k < 0) ready_k = k;
      end
      check($sformatf("v%0d_done_count", v), n_done, vecs[v].exp_done);
      check($sformatf("v%0d_timeout_count", v), n_to, vecs[v].exp_to);
      check($sformatf("v%0d_pulse_edge", v), pulse_k, vecs[v].exp_pulse_k);
      check($sformatf("v%0d_ready_edge", v), ready_k, vecs[v].exp_ready_k);
      check($sformatf("v%0d_req_cycles", v), req_cyc, vecs[v].exp_req_cycles);
      check($sformatf("v%0d_dout_during_req", v), dout_bad, 0);
      check($sformatf("v%0d_dout_held", v), int'(dout), int'(vecs[v].din));
    end

    // Back-to-back: valid stays high and din changes every cycle. Immediate ack
    // gives one accept every 7 edges, so the accepted words are 01, 08, 0F, 16.
    peer_mode = 2'd2;
    rises = 0; unstable = 0; req_prev = 1'b0; dout_prev = 8'h00;
    for (int e = 0; e < 28; e++) begin
      @(negedge clk);
      valid = 1'b1;
      din = 8'(8'h01 + e);
      @(posedge clk); #1;
      if (req && !req_prev) begin
        check($sformatf("b2b_word%0d", rises), int'(dout), 1 + 7 * rises);
        rises++;
      end else if (req && req_prev && (dout != dout_prev)) begin
        unstable++;
      end
      req_prev = req;
      dout_prev = dout;
    end
    @(negedge clk);
    valid = 1'b0;
    check("b2b_accept_count", rises, 4);
    check("b2b_dout_stable", unstable, 0);
    check("b2b_ready_end", int'(ready), 1);

    // Reset while in WAIT_ACK with ack tied low.
    peer_mode = 2'd0;
    repeat (3) @(negedge clk);
    valid = 1'b1; din = 8'hC3;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
    check("midreset_req", int'(req), 0);
    check("midreset_dout", int'(dout), 0);
    check("midreset_ready", int'(ready), 1);
    @(negedge clk);
    res = 1'b0;
    n_done = 0; n_to = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
      if (timeout) n_to++;
    end
    check("midreset_no_done", n_done, 0);
    check("midreset_no_timeout", n_to, 0);

    // Stray ack in IDLE must not start a transfer.
    req_cyc = 0; n_done = 0; n_to = 0; ready_k = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ack_man = (k < 5);
      @(posedge clk); #1;
      if (req) req_cyc++;
      if (done) n_done++;
      if (timeout) n_to++;
      if (!ready) ready_k++;
    end
    check("stray_req", req_cyc, 0);
    check("stray_done", n_done, 0);
    check("stray_timeout", n_to, 0);
    check("stray_ready_low", ready_k, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
